fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO among REQ_NUM requesters, for example DMA channels or peripheral RX paths.
- Grants are packet-locked. A granted requester keeps the port until it writes a beat flagged last, or until MAX_BURST beats have been written.
- The block sits directly in front of the FIFO. It drives the FIFO's write enable and write data, and reads back only the FIFO's full flag.

Parameters:
REQ_NUM, 4, number of requesters
REQ_BITS, 2, width of requester index; must satisfy (1<<REQ_BITS) >= REQ_NUM
DATA_BITS, 32, FIFO data width
MAX_BURST, 16, maximum beats per grant before forced release; range 1 to (1<<BURST_BITS)-1
BURST_BITS, 5, width of beat counter

Ports:
clk  input  1  main clock
rst  input  1  synchronous reset, active-high
req  input  REQ_NUM  per-requester write request; data is valid while high
data  input  REQ_NUM*DATA_BITS  per-requester write data; requester i occupies bits [i*DATA_BITS +: DATA_BITS]
last  input  REQ_NUM  per-requester end-of-packet flag, qualified by req
ack  output  REQ_NUM  per-requester beat-accepted strobe (combinational)
fifo_full  input  1  FIFO full flag
fifo_en_w  output  1  FIFO write enable (combinational)
fifo_data_w  output  DATA_BITS  FIFO write data (combinational mux)
grant_valid  output  1  arbiter is locked to a requester (registered)
grant_id  output  REQ_BITS  index of the locked requester (registered)
beat_count  output  BURST_BITS  beats written in the current grant (registered)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - grant_valid=0, grant_id=0, beat_count=0.
  - Internal last-served pointer = REQ_NUM-1, so requester 0 has first priority.
  - FSM in IDLE.
- FSM has two states, IDLE and LOCK.
- In IDLE:
  - ack=0 and fifo_en_w=0.
  - If any req bit is high, select the first set bit in rotating order last_served+1, last_served+2, …, wrapping modulo REQ_NUM.
  - Next cycle: grant_valid=1, grant_id=selected index, beat_count=0, state=LOCK.
  - Grant latency is exactly 1 cycle from req rising to grant_valid. The first ack is possible in that LOCK cycle.
- In LOCK, with g = grant_id:
  - fifo_data_w = data[g].
  - fifo_en_w = req[g] & ~fifo_full.
  - ack[g] = fifo_en_w. All other ack bits are 0.
  - fifo_data_w is don't-care when fifo_en_w=0. It outputs data[grant_id] in all states.
- A beat is accepted in a cycle where ack[g]=1. Each accepted beat increments beat_count.
- Release: an accepted beat with last[g]=1, or an accepted beat that makes beat_count+1 == MAX_BURST.
  - Next cycle: state=IDLE, grant_valid=0, beat_count=0, last_served=g.
  - In that IDLE cycle the arbiter may immediately evaluate req again. The minimum gap between grants is therefore 1 idle cycle.
- If req[g] falls while locked, the grant is held, nothing is written and beat_count is unchanged. There is no timeout; the requester must finish its packet.
- fifo_full=1 stalls: no ack, no count, no write. Data must be held by the requester. The beat is accepted when fifo_full falls.
- last without req is ignored. Requests from non-granted requesters are ignored while in LOCK.
- A forced release at MAX_BURST does not require last. A requester that is still requesting is re-queued behind the others by round-robin order.
- rst mid-packet:
  - Outputs return to reset values on the next edge.
  - ack and fifo_en_w are forced to 0 during any cycle in which rst=1, even if in LOCK.
  - Partial packets already in the FIFO are not reclaimed.
- Widths: beat_count wraps never, because the MAX_BURST release precedes overflow. Pointer arithmetic is modulo REQ_NUM, not modulo 1<<REQ_BITS.

Test Plan:
1. Reset → grant_valid=0, grant_id=0, ack=0, fifo_en_w=0. Then req=4'b1111, last all 1 → grants 0,1,2,3,0 in order. Each grant is 1 beat and grants are 2 cycles apart.
2. req[2]=1 with a 3-beat packet (data 0xA0, 0xA1, 0xA2, last on the third beat), then req[1] raised mid-packet → fifo sees A0, A1, A2 on consecutive cycles, and grant_id=1 only after release.
3. Hold fifo_full=1 for 3 cycles during a granted packet → fifo_en_w=0 and ack=0 in those cycles, beat_count frozen. The beat is written in the cycle fifo_full drops, with no data loss or duplication.
4. MAX_BURST=4, req[0] streams 10 beats with last=0 and req[3]=1 → 4 beats from 0, then grant to 3, then 0 resumes. beat_count reaches 3 before release.
5. Granted requester deasserts req for 5 cycles mid-packet while others request → grant held, no writes, no grant change. Packet completes after req returns.
6. Assert rst while LOCK with beat_count=2 → the next cycle shows grant_valid=0, beat_count=0, and ack/fifo_en_w low during rst. The next arbitration starts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Packet-locked round-robin arbiter sharing one FIFO write port
//            among REQ_NUM requesters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int REQ_BITS   = 2,
    parameter int DATA_BITS  = 32,
    parameter int MAX_BURST  = 16,
    parameter int BURST_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            req,
    input  logic [REQ_NUM*DATA_BITS-1:0]  data,
    input  logic [REQ_NUM-1:0]            last,
    output logic [REQ_NUM-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_en_w,
    output logic [DATA_BITS-1:0]          fifo_data_w,
    output logic                          grant_valid,
    output logic [REQ_BITS-1:0]           grant_id,
    output logic [BURST_BITS-1:0]         beat_count
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_LOCK = 1'b1;

    localparam logic [REQ_BITS-1:0]   c_LAST_INIT = REQ_BITS'(REQ_NUM - 1);
    localparam logic [BURST_BITS-1:0] c_MAX_BEAT  = BURST_BITS'(MAX_BURST);

    logic [0:0]            r_state;
    logic [REQ_BITS-1:0]   r_grant_id;
    logic [REQ_BITS-1:0]   r_last_ptr;
    logic [BURST_BITS-1:0] r_beat_count;

    logic                  w_found;
    logic [REQ_BITS-1:0]   w_sel;
    logic                  w_en;
    logic                  w_release;
    logic [DATA_BITS-1:0]  w_data_arr [REQ_NUM];

    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
        assign w_data_arr[gi] = data[gi*DATA_BITS +: DATA_BITS];
    end

    // Wraps modulo REQ_NUM so non-power-of-two requester counts rotate correctly.
    function automatic logic [REQ_BITS-1:0] rr_index(input logic [REQ_BITS-1:0] base,
                                                     input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= REQ_NUM) begin
            sum = sum - REQ_NUM;
        end
        return REQ_BITS'(sum);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            if (!w_found && req[rr_index(r_last_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = rr_index(r_last_ptr, k);
            end
        end
    end

    assign w_en      = (r_state == c_LOCK) && req[r_grant_id] && !fifo_full && !rst;
    assign w_release = w_en && (last[r_grant_id] ||
                                ((r_beat_count + BURST_BITS'(1)) == c_MAX_BEAT));

    always_comb begin
        ack = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            ack[i] = w_en && (r_grant_id == REQ_BITS'(i));
        end
    end

    assign fifo_en_w   = w_en;
    assign fifo_data_w = w_data_arr[r_grant_id];
    assign grant_valid = (r_state == c_LOCK);
    assign grant_id    = r_grant_id;
    assign beat_count  = r_beat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant_id   <= '0;
            r_last_ptr   <= c_LAST_INIT;
            r_beat_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state      <= c_LOCK;
                        r_grant_id   <= w_sel;
                        r_beat_count <= '0;
                    end
                end
                c_LOCK: begin
                    if (w_release) begin
                        r_state      <= c_IDLE;
                        r_beat_count <= '0;
                        r_last_ptr   <= r_grant_id;
                    end else if (w_en) begin
                        r_beat_count <= r_beat_count + BURST_BITS'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter (vector table, directed
//            packet sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int RB   = 2;
    localparam int DB   = 32;
    localparam int MAXB = 4;
    localparam int BB   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DB-1:0]   data;
    logic [N-1:0]      last;
    logic [N-1:0]      ack;
    logic              fifo_full;
    logic              fifo_en_w;
    logic [DB-1:0]     fifo_data_w;
    logic              grant_valid;
    logic [RB-1:0]     grant_id;
    logic [BB-1:0]     beat_count;

    fifo_wr_arbiter #(
        .REQ_NUM(N), .REQ_BITS(RB), .DATA_BITS(DB), .MAX_BURST(MAXB), .BURST_BITS(BB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .last(last), .ack(ack),
        .fifo_full(fifo_full), .fifo_en_w(fifo_en_w), .fifo_data_w(fifo_data_w),
        .grant_valid(grant_valid), .grant_id(grant_id), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference state
    bit m_locked;
    int m_gid;
    int m_cnt;
    int m_ptr;
    logic [DB-1:0] dut_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] req_data(input int i);
        return data[i*DB +: DB];
    endfunction

    function automatic bit m_en();
        return !rst && m_locked && req[m_gid] && !fifo_full;
    endfunction

    task automatic set_data(input int i, input logic [DB-1:0] v);
        data[i*DB +: DB] = v;
    endtask

    task automatic drive(input bit r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                         input bit full);
        rst = r; req = rq; last = ls; fifo_full = full;
    endtask

    task automatic settle_check();
        logic [N-1:0] exp_ack;
        @(negedge clk);
        exp_ack = m_en() ? N'(1 << m_gid) : '0;
        chk("grant_valid", 32'(grant_valid), 32'(m_locked));
        if (m_locked) chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("beat_count", 32'(beat_count), 32'(m_cnt));
        chk("fifo_en_w", 32'(fifo_en_w), 32'(m_en()));
        chk("ack", 32'(ack), 32'(exp_ack));
        if (m_en()) chk("fifo_data_w", fifo_data_w, req_data(m_gid));
        if (fifo_en_w === 1'b1) dut_log.push_back(fifo_data_w);
    endtask

    task automatic edge_update();
        bit found;
        @(posedge clk);
        if (rst) begin
            m_locked = 0; m_gid = 0; m_cnt = 0; m_ptr = N - 1;
        end else if (!m_locked) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1; m_locked = 1; m_gid = (m_ptr + k) % N; m_cnt = 0;
                end
            end
        end else if (m_en()) begin
            if (last[m_gid] || (m_cnt + 1 == MAXB)) begin
                m_locked = 0; m_cnt = 0; m_ptr = m_gid;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                       input bit full);
        drive(r, rq, ls, full);
        settle_check();
        edge_update();
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0);
        edge_update();
        dut_log.delete();
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        logic [N-1:0] last;
        bit           full;
        bit           gv;
        int           gid;
        bit           gid_chk;
        int           bc;
        bit           en;
        logic [N-1:0] ack;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int d0cnt, d3cnt, maxbc;
        bit a0, a3;

        for (int i = 0; i < N; i++) set_data(i, DB'(32'h100 + i));
        drive(1'b1, '0, '0, 1'b0);
        @(posedge clk); #1;

        //          rst req     last    full gv gid chk bc en ack
        vecs[0]  = '{1, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0};
        vecs[1]  = '{0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 4'h0};
        vecs[2]  = '{0, 4'hF, 4'hF, 0, 1, 0, 1, 0, 1, 4'h1};
        vecs[3]  = '{0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0};
        vecs[4]  = '{0, 4'hF, 4'hF, 0, 1, 1, 1, 0, 1, 4'h2};
        vecs[5]  = '{0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0};
        vecs[6]  = '{0, 4'hF, 4'hF, 0, 1, 2, 1, 0, 1, 4'h4};
        vecs[7]  = '{0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0};
        vecs[8]  = '{0, 4'hF, 4'hF, 0, 1, 3, 1, 0, 1, 4'h8};
        vecs[9]  = '{0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0};
        vecs[10] = '{0, 4'hF, 4'hF, 0, 1, 0, 1, 0, 1, 4'h1};
        vecs[11] = '{0, 4'h4, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0};
        vecs[12] = '{0, 4'h4, 4'h0, 0, 1, 2, 1, 0, 1, 4'h4};
        vecs[13] = '{0, 4'h4, 4'h0, 0, 1, 2, 1, 1, 1, 4'h4};
        vecs[14] = '{1, 4'h4, 4'h0, 0, 1, 2, 1, 2, 0, 4'h0};
        vecs[15] = '{0, 4'hF, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0};
        vecs[16] = '{0, 4'hF, 4'h0, 0, 1, 0, 1, 0, 1, 4'h1};
        vecs[17] = '{0, 4'hF, 4'h0, 1, 1, 0, 1, 1, 0, 4'h0};
        vecs[18] = '{0, 4'hF, 4'hF, 0, 1, 0, 1, 1, 1, 4'h1};
        vecs[19] = '{0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0};

        for (int v = 0; v < 20; v++) begin
            drive(vecs[v].rst, vecs[v].req, vecs[v].last, vecs[v].full);
            @(negedge clk);
            chk($sformatf("vec%0d grant_valid", v), 32'(grant_valid), 32'(vecs[v].gv));
            if (vecs[v].gid_chk)
                chk($sformatf("vec%0d grant_id", v), 32'(grant_id), 32'(vecs[v].gid));
            chk($sformatf("vec%0d beat_count", v), 32'(beat_count), 32'(vecs[v].bc));
            chk($sformatf("vec%0d fifo_en_w", v), 32'(fifo_en_w), 32'(vecs[v].en));
            chk($sformatf("vec%0d ack", v), 32'(ack), 32'(vecs[v].ack));
            if (vecs[v].en)
                chk($sformatf("vec%0d fifo_data_w", v), fifo_data_w,
                    DB'(32'h100 + vecs[v].gid));
            @(posedge clk); #1;
        end

        // Packet from requester 2 is not interrupted by requester 1
        do_reset();
        set_data(1, 32'h11); set_data(2, 32'hA0);
        cyc(0, 4'b0100, 4'b0000, 0);
        cyc(0, 4'b0110, 4'b0000, 0);
        set_data(2, 32'hA1);
        cyc(0, 4'b0110, 4'b0000, 0);
        set_data(2, 32'hA2);
        cyc(0, 4'b0110, 4'b0100, 0);
        cyc(0, 4'b0010, 4'b0000, 0);
        chk("pkt2 grant_id after release", 32'(grant_id), 32'd1);
        chk("pkt2 write count", 32'(dut_log.size()), 32'd3);
        if (dut_log.size() == 3) begin
            chk("pkt2 beat0", dut_log[0], 32'hA0);
            chk("pkt2 beat1", dut_log[1], 32'hA1);
            chk("pkt2 beat2", dut_log[2], 32'hA2);
        end

        // fifo_full stall for three cycles
        do_reset();
        set_data(0, 32'hB0);
        cyc(0, 4'b0001, 4'b0000, 0);
        cyc(0, 4'b0001, 4'b0000, 0);
        set_data(0, 32'hB1);
        for (int i = 0; i < 3; i++) cyc(0, 4'b0001, 4'b0001, 1);
        chk("stall beat_count frozen", 32'(beat_count), 32'd1);
        cyc(0, 4'b0001, 4'b0001, 0);
        cyc(0, 4'b0000, 4'b0000, 0);
        chk("stall write count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) chk("stall beat1", dut_log[1], 32'hB1);

        // Forced release at MAX_BURST with requester 3 waiting
        do_reset();
        d0cnt = 0; d3cnt = 0; maxbc = 0;
        for (int c = 0; c < 40; c++) begin
            set_data(0, DB'(32'hC0 + d0cnt));
            set_data(3, DB'(32'hE0 + d3cnt));
            drive(0, {d3cnt < 1, 2'b00, d0cnt < 10}, 4'b1000, 0);
            settle_check();
            a0 = m_en() && m_gid == 0;
            a3 = m_en() && m_gid == 3;
            if (int'(beat_count) > maxbc) maxbc = int'(beat_count);
            edge_update();
            if (a0) d0cnt++;
            if (a3) d3cnt++;
        end
        chk("burst max beat_count", 32'(maxbc), 32'd3);
        chk("burst write count", 32'(dut_log.size()), 32'd11);
        if (dut_log.size() >= 6) begin
            chk("burst beat3", dut_log[3], 32'hC3);
            chk("burst req3 beat", dut_log[4], 32'hE0);
            chk("burst resume", dut_log[5], 32'hC4);
        end

        // Granted requester drops req mid-packet
        do_reset();
        set_data(0, 32'hD0);
        cyc(0, 4'b0001, 4'b0000, 0);
        cyc(0, 4'b0001, 4'b0000, 0);
        for (int i = 0; i < 5; i++) cyc(0, 4'b1110, 4'b0000, 0);
        chk("hold grant_valid", 32'(grant_valid), 32'd1);
        chk("hold grant_id", 32'(grant_id), 32'd0);
        set_data(0, 32'hD1);
        cyc(0, 4'b1111, 4'b0001, 0);
        cyc(0, 4'b1110, 4'b0000, 0);
        chk("hold next grant", 32'(grant_id), 32'd1);
        chk("hold write count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) chk("hold beat1", dut_log[1], 32'hD1);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) set_data(i, DB'($urandom));
            cyc($urandom_range(0, 127) == 0, N'($urandom), N'($urandom_range(0, 15) &
                $urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
